irq_ctrl: RTL and testbench

Interrupt controller for the core's program sequencer. It edge-detects and latches external interrupt sources, applies a programmable mask and global enable, and resolves fixed priority with nesting. It presents one vectored request to the program sequencer, which acknowledges it when it branches. It also wakes the sequencer out of IDLE, and it sits between the core-level `interrupt` pins and `ps` inside `core_top`.

---
 rtl/irq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched sources, mask/GIE gating, fixed priority with
// nesting via IMASKP, and a single registered vectored request to the sequencer.
module irq_ctrl #(
    parameter int PMA_SIZE      = 16,
    parameter int IRQ_COUNT     = 4,
    parameter int VECTOR_BASE   = 16'h0008,
    parameter int VECTOR_STRIDE = 4,
    parameter int RF_DATASIZE   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IRQ_COUNT-1:0]   irq_in,
    input  logic                   ps_idle,
    input  logic                   ps_irq_ack,
    input  logic                   ps_rti,
    input  logic                   cfg_wr_en,
    input  logic [1:0]             cfg_sel,
    input  logic [RF_DATASIZE-1:0] cfg_wr_data,
    output logic [RF_DATASIZE-1:0] cfg_rd_data,
    output logic                   irq_req,
    output logic [PMA_SIZE-1:0]    irq_vec,
    output logic [2:0]             irq_num,
    output logic                   ic_wake
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [IRQ_COUNT-1:0] ONE = IRQ_COUNT'(1);

    function automatic logic [PMA_SIZE-1:0] vec_addr(input logic [2:0] n);
        return PMA_SIZE'(VECTOR_BASE) + PMA_SIZE'(n) * PMA_SIZE'(VECTOR_STRIDE);
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IRQ_COUNT-1:0]   r_irq_prev;
    logic [IRQ_COUNT-1:0]   r_irptl;
    logic [IRQ_COUNT-1:0]   r_imask;
    logic [IRQ_COUNT-1:0]   r_imaskp;
    logic                   r_gie;
    logic [2:0]             r_irq_num;
    logic [PMA_SIZE-1:0]    r_irq_vec;

    logic [IRQ_COUNT-1:0]   w_edge;
    logic [IRQ_COUNT-1:0]   w_pending;
    logic [IRQ_COUNT-1:0]   w_imaskp_low;
    logic [IRQ_COUNT-1:0]   w_elig_mask;
    logic [IRQ_COUNT-1:0]   w_eligible;
    logic                   w_any;
    logic [2:0]             w_winner;
    logic [IRQ_COUNT-1:0]   w_num_oh;
    logic                   w_ack;
    logic                   w_withdraw;
    logic                   w_latch;
    logic                   w_wr_imask;
    logic                   w_wr_irptl;
    logic                   w_wr_mode;
    logic [IRQ_COUNT-1:0]   w_irptl_nxt;
    logic [IRQ_COUNT-1:0]   w_imaskp_nxt;
    logic                   w_unused_wr;

    assign w_unused_wr = ^cfg_wr_data[RF_DATASIZE-1:IRQ_COUNT];

    assign w_edge    = irq_in & ~r_irq_prev;
    assign w_pending = r_irptl & r_imask & {IRQ_COUNT{r_gie}};

    // Only sources of strictly higher priority than the innermost in-service one may nest.
    assign w_imaskp_low = r_imaskp & (~r_imaskp + ONE);
    assign w_elig_mask  = (r_imaskp == '0) ? '1 : (w_imaskp_low - ONE);
    assign w_eligible   = w_pending & w_elig_mask;
    assign w_any        = |w_eligible;

    always_comb begin
        w_winner = 3'd0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    assign w_num_oh   = ONE << r_irq_num;
    assign w_ack      = (r_state == S_REQ) && ps_irq_ack;
    assign w_withdraw = !r_gie || ((r_irptl & r_imask & w_num_oh) == '0);
    assign w_latch    = (r_state == S_IDLE) && w_any;

    assign w_wr_imask = cfg_wr_en && (cfg_sel == 2'd0);
    assign w_wr_irptl = cfg_wr_en && (cfg_sel == 2'd1);
    assign w_wr_mode  = cfg_wr_en && (cfg_sel == 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack || w_withdraw) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Software write, then ack clear, then edge set: a coincident edge always wins.
    always_comb begin
        w_irptl_nxt = r_irptl;
        if (w_wr_irptl) begin
            w_irptl_nxt = cfg_wr_data[IRQ_COUNT-1:0];
        end
        if (w_ack) begin
            w_irptl_nxt = w_irptl_nxt & ~w_num_oh;
        end
        w_irptl_nxt = w_irptl_nxt | w_edge;
    end

    always_comb begin
        w_imaskp_nxt = r_imaskp;
        if (ps_rti) begin
            w_imaskp_nxt = r_imaskp & (r_imaskp - ONE);
        end
        if (w_ack) begin
            w_imaskp_nxt = w_imaskp_nxt | w_num_oh;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_irq_prev <= '0;
            r_irptl    <= '0;
            r_imask    <= '0;
            r_imaskp   <= '0;
            r_gie      <= 1'b0;
            r_irq_num  <= 3'd0;
            r_irq_vec  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq_prev <= irq_in;
            r_irptl    <= w_irptl_nxt;
            r_imaskp   <= w_imaskp_nxt;
            if (w_wr_imask) begin
                r_imask <= cfg_wr_data[IRQ_COUNT-1:0];
            end
            if (w_wr_mode) begin
                r_gie <= cfg_wr_data[0];
            end
            if (w_latch) begin
                r_irq_num <= w_winner;
                r_irq_vec <= vec_addr(w_winner);
            end
        end
    end

    always_comb begin
        cfg_rd_data = '0;
        case (cfg_sel)
            2'd0:    cfg_rd_data = {{(RF_DATASIZE-IRQ_COUNT){1'b0}}, r_imask};
            2'd1:    cfg_rd_data = {{(RF_DATASIZE-IRQ_COUNT){1'b0}}, r_irptl};
            2'd2:    cfg_rd_data = {{(RF_DATASIZE-1){1'b0}}, r_gie};
            default: cfg_rd_data = {{(RF_DATASIZE-IRQ_COUNT){1'b0}}, r_imaskp};
        endcase
    end

    assign irq_req = (r_state == S_REQ);
    assign irq_vec = r_irq_vec;
    assign irq_num = r_irq_num;
    assign ic_wake = ps_idle & irq_req;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: latency, priority, nesting, masking,
// wake, level hold, coincident set/clear and asynchronous reset.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        ps_idle;
    logic        ps_irq_ack;
    logic        ps_rti;
    logic        cfg_wr_en;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_wr_data;
    logic [15:0] cfg_rd_data;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic [2:0]  irq_num;
    logic        ic_wake;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .ps_idle    (ps_idle),
        .ps_irq_ack (ps_irq_ack),
        .ps_rti     (ps_rti),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_sel    (cfg_sel),
        .cfg_wr_data(cfg_wr_data),
        .cfg_rd_data(cfg_rd_data),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .irq_num    (irq_num),
        .ic_wake    (ic_wake)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        cfg_wr_en   = 1'b1;
        cfg_sel     = sel;
        cfg_wr_data = data;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] sel, output logic [15:0] v);
        cfg_sel = sel;
        #1;
        v = cfg_rd_data;
    endtask

    task automatic pulse_ack();
        ps_irq_ack = 1'b1;
        tick();
        ps_irq_ack = 1'b0;
    endtask

    task automatic pulse_rti();
        ps_rti = 1'b1;
        tick();
        ps_rti = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq_in = '0; ps_idle = 1'b1; ps_irq_ack = 1'b0; ps_rti = 1'b0;
        cfg_wr_en = 1'b0; cfg_sel = 2'd0; cfg_wr_data = '0;
        tick(); tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", irq_req); end
        checks++; if (irq_vec !== 16'h0) begin errors++; $display("FAIL reset_vec got %h want 0000", irq_vec); end
        checks++; if (irq_num !== 3'd0) begin errors++; $display("FAIL reset_num got %0d want 0", irq_num); end
        checks++; if (ic_wake !== 1'b0) begin errors++; $display("FAIL reset_wake got %0b want 0", ic_wake); end
        for (int s = 0; s < 4; s++) begin
            rd_reg(2'(s), rd);
            checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 0000", s, rd); end
        end
        ps_idle = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        cfg_write(2'd2, 16'h0001);
        cfg_write(2'd0, 16'h000F);
        irq_in = 4'b0100; tick(); irq_in = '0;
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL basic_irptl got %h want 0004", rd); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got %0b want 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL basic_req got %0b want 1", irq_req); end
        checks++; if (irq_num !== 3'd2) begin errors++; $display("FAIL basic_num got %0d want 2", irq_num); end
        checks++; if (irq_vec !== 16'h0010) begin errors++; $display("FAIL basic_vec got %h want 0010", irq_vec); end
        pulse_ack();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_ack_req got %0b want 0", irq_req); end
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL basic_imaskp got %h want 0004", rd); end
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL basic_irptl_clr got %h want 0000", rd); end
    endtask

    task automatic test_nesting();
        irq_in = 4'b0001; tick(); irq_in = '0; tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL nest_req got %0b want 1", irq_req); end
        checks++; if (irq_vec !== 16'h0008) begin errors++; $display("FAIL nest_vec got %h want 0008", irq_vec); end
        checks++; if (irq_num !== 3'd0) begin errors++; $display("FAIL nest_num got %0d want 0", irq_num); end
        pulse_ack();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL nest_imaskp got %h want 0005", rd); end
        pulse_rti();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL nest_rti1 got %h want 0004", rd); end
        pulse_rti();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL nest_rti2 got %h want 0000", rd); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL nest_idle got %0b want 0", irq_req); end
    endtask

    task automatic test_priority();
        irq_in = 4'b1010; tick(); irq_in = '0;
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL prio_irptl got %h want 000a", rd); end
        tick();
        checks++; if (irq_num !== 3'd1) begin errors++; $display("FAIL prio_num got %0d want 1", irq_num); end
        checks++; if (irq_vec !== 16'h000C) begin errors++; $display("FAIL prio_vec got %h want 000c", irq_vec); end
        pulse_ack();
        tick(); tick(); tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_blocked got %0b want 0", irq_req); end
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0008) begin errors++; $display("FAIL prio_irptl3 got %h want 0008", rd); end
        pulse_rti();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL prio_rti_edge got %0b want 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL prio_req3 got %0b want 1", irq_req); end
        checks++; if (irq_num !== 3'd3) begin errors++; $display("FAIL prio_num3 got %0d want 3", irq_num); end
        checks++; if (irq_vec !== 16'h0014) begin errors++; $display("FAIL prio_vec3 got %h want 0014", irq_vec); end
        pulse_ack();
        pulse_rti();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL prio_imaskp got %h want 0000", rd); end
    endtask

    task automatic test_mask();
        cfg_write(2'd0, 16'h0000);
        irq_in = 4'b0010; tick(); irq_in = '0; tick(); tick();
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL mask_irptl got %h want 0002", rd); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_noreq got %0b want 0", irq_req); end
        cfg_write(2'd0, 16'h0002);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_wr_edge got %0b want 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL mask_req got %0b want 1", irq_req); end
        checks++; if (irq_num !== 3'd1) begin errors++; $display("FAIL mask_num got %0d want 1", irq_num); end
        cfg_write(2'd2, 16'h0000);
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL gie_withdraw got %0b want 0", irq_req); end
        cfg_write(2'd2, 16'h0001);
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL gie_rereq got %0b want 1", irq_req); end
        pulse_ack();
        pulse_rti();
        cfg_write(2'd0, 16'h000F);
        rd_reg(2'd0, rd);
        checks++; if (rd !== 16'h000F) begin errors++; $display("FAIL mask_readback got %h want 000f", rd); end
    endtask

    task automatic test_wake();
        ps_idle = 1'b1;
        irq_in = 4'b0001; tick(); irq_in = '0;
        checks++; if (ic_wake !== 1'b0) begin errors++; $display("FAIL wake_early got %0b want 0", ic_wake); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL wake_req got %0b want 1", irq_req); end
        checks++; if (ic_wake !== 1'b1) begin errors++; $display("FAIL wake got %0b want 1", ic_wake); end
        ps_idle = 1'b0; #1;
        checks++; if (ic_wake !== 1'b0) begin errors++; $display("FAIL wake_noidle got %0b want 0", ic_wake); end
        pulse_ack();
        pulse_rti();
    endtask

    task automatic test_level();
        irq_in = 4'b0001; tick(); tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL level_req got %0b want 1", irq_req); end
        pulse_ack();
        pulse_rti();
        for (int c = 0; c < 6; c++) tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL level_retrig got %0b want 0", irq_req); end
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL level_irptl got %h want 0000", rd); end
        irq_in = '0; tick();
    endtask

    task automatic test_back_to_back();
        irq_in = 4'b0100; tick(); irq_in = '0; tick();
        checks++; if (irq_num !== 3'd2) begin errors++; $display("FAIL b2b_num got %0d want 2", irq_num); end
        irq_in = 4'b0100; ps_irq_ack = 1'b1; tick(); ps_irq_ack = 1'b0; irq_in = '0;
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL b2b_setwins got %h want 0004", rd); end
        rd_reg(2'd3, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL b2b_imaskp got %h want 0004", rd); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL b2b_ackreq got %0b want 0", irq_req); end
        pulse_rti();
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL b2b_rereq got %0b want 1", irq_req); end
        pulse_ack();
        pulse_rti();
    endtask

    task automatic test_reset_mid();
        irq_in = 4'b0100; tick(); irq_in = 4'b1000; tick(); irq_in = '0;
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %0b want 1", irq_req); end
        #2; reset = 1'b0; #1;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rstmid_req0 got %0b want 0", irq_req); end
        checks++; if (irq_vec !== 16'h0) begin errors++; $display("FAIL rstmid_vec got %h want 0000", irq_vec); end
        checks++; if (irq_num !== 3'd0) begin errors++; $display("FAIL rstmid_num got %0d want 0", irq_num); end
        rd_reg(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_irptl got %h want 0000", rd); end
        rd_reg(2'd2, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_gie got %h want 0000", rd); end
        tick();
        reset = 1'b1;
        cfg_write(2'd2, 16'h0001);
        cfg_write(2'd0, 16'h000F);
        tick(); tick(); tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rstmid_noreq got %0b want 0", irq_req); end
        irq_in = 4'b0010; tick(); irq_in = '0; tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL rstmid_newreq got %0b want 1", irq_req); end
        checks++; if (irq_num !== 3'd1) begin errors++; $display("FAIL rstmid_newnum got %0d want 1", irq_num); end
        pulse_ack();
        pulse_rti();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_priority();
        test_mask();
        test_wake();
        test_level();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
